// File: rtl/perceptron_error_unit.sv
// Error/backprop-delta pipeline (3 stages) with per-epoch sum-of-squared-error accumulation.
// Optional macro SSE_SAT_EN: clamp the SSE accumulator at its maximum instead of wrapping.
module perceptron_error_unit #(
    parameter int DWIDTH    = 32,
    parameter int FRAC      = 24,
    parameter int ACC_W     = 40,
    parameter int CNT_W     = 16,
    parameter int N_SAMPLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] y,
    input  logic [DWIDTH-1:0] target,
    output logic              out_valid,
    output logic [DWIDTH-1:0] delta,
    output logic [ACC_W-1:0]  sse,
    output logic              epoch_done,
    output logic [CNT_W-1:0]  sample_cnt
);

`ifdef SSE_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    localparam int SUM_W = ((ACC_W > DWIDTH) ? ACC_W : DWIDTH) + 1;
    localparam logic [DWIDTH-1:0] SMAX_C = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam logic [DWIDTH-1:0] SMIN_C = {1'b1, {(DWIDTH-1){1'b0}}};
    localparam logic [DWIDTH-1:0] ONE_C  = {{(DWIDTH-1){1'b0}}, 1'b1} << FRAC;

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    // a - b computed one bit wider, then saturated back to the signed DWIDTH range.
    function automatic logic [DWIDTH-1:0] sat_sub(input logic [DWIDTH-1:0] a,
                                                  input logic [DWIDTH-1:0] b);
        logic [DWIDTH:0] d;
        d = {a[DWIDTH-1], a} - {b[DWIDTH-1], b};
        if (d[DWIDTH] != d[DWIDTH-1]) begin
            sat_sub = d[DWIDTH] ? SMIN_C : SMAX_C;
        end else begin
            sat_sub = d[DWIDTH-1:0];
        end
    endfunction

    // Fixed-point multiply: full signed product, floor shift by FRAC, saturate to DWIDTH.
    function automatic logic [DWIDTH-1:0] fx_mul(input logic [DWIDTH-1:0] a,
                                                 input logic [DWIDTH-1:0] b);
        logic signed [2*DWIDTH-1:0] prod;
        logic signed [2*DWIDTH-1:0] shf;
        prod = $signed({{DWIDTH{a[DWIDTH-1]}}, a}) * $signed({{DWIDTH{b[DWIDTH-1]}}, b});
        shf  = prod >>> FRAC;
        if ((shf[2*DWIDTH-1:DWIDTH-1] == {(DWIDTH+1){1'b0}}) ||
            (shf[2*DWIDTH-1:DWIDTH-1] == {(DWIDTH+1){1'b1}})) begin
            fx_mul = shf[DWIDTH-1:0];
        end else begin
            fx_mul = shf[2*DWIDTH-1] ? SMIN_C : SMAX_C;
        end
    endfunction

    logic              v1_r, v2_r, ov_r;
    logic [DWIDTH-1:0] e1_r, omy1_r, y1_r;
    logic [DWIDTH-1:0] p2_r, sq2_r, omy2_r;
    logic [DWIDTH-1:0] delta_r;
    logic [DWIDTH-1:0] sq_full_s, sq_s;
    logic [ACC_W-1:0]  acc_r, acc_s, sse_r, sse_s, acc_sum_s;
    logic [SUM_W-1:0]  sum_s;
    logic              ovf_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s, cnt_inc_s;
    state_t            state_r, state_s;

    // Square of the error, clamped non-negative before it enters the accumulator.
    always_comb begin
        sq_full_s = fx_mul(e1_r, e1_r);
        if (sq_full_s[DWIDTH-1]) begin
            sq_s = {DWIDTH{1'b0}};
        end else begin
            sq_s = sq_full_s;
        end
    end

    // Three-stage error/delta pipeline; clr kills every in-flight valid, data regs just hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r    <= 1'b0;
            v2_r    <= 1'b0;
            ov_r    <= 1'b0;
            e1_r    <= {DWIDTH{1'b0}};
            omy1_r  <= {DWIDTH{1'b0}};
            y1_r    <= {DWIDTH{1'b0}};
            p2_r    <= {DWIDTH{1'b0}};
            sq2_r   <= {DWIDTH{1'b0}};
            omy2_r  <= {DWIDTH{1'b0}};
            delta_r <= {DWIDTH{1'b0}};
        end else begin
            if (clr) begin
                v1_r <= 1'b0;
                v2_r <= 1'b0;
                ov_r <= 1'b0;
            end else begin
                v1_r <= in_valid;
                v2_r <= v1_r;
                ov_r <= v2_r;
            end
            if (in_valid) begin
                e1_r   <= sat_sub(target, y);
                omy1_r <= sat_sub(ONE_C, y);
                y1_r   <= y;
            end
            if (v1_r) begin
                p2_r   <= fx_mul(e1_r, y1_r);
                sq2_r  <= sq_s;
                omy2_r <= omy1_r;
            end
            if (v2_r) begin
                delta_r <= fx_mul(p2_r, omy2_r);
            end
        end
    end

    // Epoch FSM: the sample retiring this cycle either extends the epoch or closes it.
    always_comb begin
        sum_s     = {{(SUM_W-ACC_W){1'b0}}, acc_r} + {{(SUM_W-DWIDTH){1'b0}}, sq2_r};
        ovf_s     = |sum_s[SUM_W-1:ACC_W];
        acc_sum_s = sum_s[ACC_W-1:0] | {ACC_W{SAT_EN & ovf_s}};
        cnt_inc_s = cnt_r + CNT_W'(1);
        state_s   = ST_ACC;
        acc_s     = acc_r;
        cnt_s     = cnt_r;
        sse_s     = sse_r;
        if (v2_r) begin
            if (cnt_inc_s == CNT_W'(N_SAMPLES)) begin
                sse_s   = acc_sum_s;
                acc_s   = {ACC_W{1'b0}};
                cnt_s   = {CNT_W{1'b0}};
                state_s = ST_DONE;
            end else begin
                acc_s   = acc_sum_s;
                cnt_s   = cnt_inc_s;
                state_s = ST_ACC;
            end
        end else begin
            state_s = ST_ACC;
        end
    end

    // Epoch state; sse survives clr and is only cleared by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_ACC;
            acc_r   <= {ACC_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            sse_r   <= {ACC_W{1'b0}};
        end else if (clr) begin
            state_r <= ST_ACC;
            acc_r   <= {ACC_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            cnt_r   <= cnt_s;
            sse_r   <= sse_s;
        end
    end

    assign out_valid  = ov_r;
    assign delta      = delta_r;
    assign sse        = sse_r;
    assign epoch_done = (state_r == ST_DONE);
    assign sample_cnt = cnt_r;

endmodule

// File: tb/tb_perceptron_error_unit.sv
// Bench for perceptron_error_unit: three instances (N=4/ACC_W=40, N=3/ACC_W=25, N=1) share one stimulus
// stream; a cycle-indexed history model predicts every output, plus directed value checks.
module tb_perceptron_error_unit;
    localparam int FR = 24;
`ifdef SSE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, clr, in_valid;
    logic [31:0] y, target;
    logic        ov0, ov1, ov2, ed0, ed1, ed2;
    logic [31:0] d0, d1, d2;
    logic [39:0] s0, s2;
    logic [24:0] s1;
    logic [15:0] c0, c1, c2;

    always #5 clk = ~clk;

    perceptron_error_unit #(.N_SAMPLES(4)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .y(y), .target(target),
        .out_valid(ov0), .delta(d0), .sse(s0), .epoch_done(ed0), .sample_cnt(c0));
    perceptron_error_unit #(.ACC_W(25), .N_SAMPLES(3)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .y(y), .target(target),
        .out_valid(ov1), .delta(d1), .sse(s1), .epoch_done(ed1), .sample_cnt(c1));
    perceptron_error_unit #(.N_SAMPLES(1)) dut2 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .y(y), .target(target),
        .out_valid(ov2), .delta(d2), .sse(s2), .epoch_done(ed2), .sample_cnt(c2));

    int errors = 0;
    int checks = 0;

    // stimulus history, indexed by clock edge number
    int     n = 0;
    bit     hv[0:4095];
    bit     hk[0:4095];
    longint hy[0:4095];
    longint ht[0:4095];

    // expected state
    int     ns[3]   = '{4, 3, 1};
    int     accw[3] = '{40, 25, 40};
    bit     m_ov;
    longint m_delta;
    longint m_acc[3];
    longint m_sse[3];
    int     m_cnt[3];
    bit     m_ed[3];

    function automatic longint sat32(input longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    function automatic longint fmul(input longint a, input longint b);
        return sat32((a * b) >>> FR);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input bit r, input bit c);
        longint e, sq, p, omy, sum, mask;
        int k;
        k = n - 2;
        if (r || c) begin
            m_ov = 1'b0;
            for (int i = 0; i < 3; i++) begin
                m_acc[i] = 0; m_cnt[i] = 0; m_ed[i] = 1'b0;
                if (r) m_sse[i] = 0;
            end
            if (r) m_delta = 0;
        end else if (n >= 3 && hv[k] && !hk[k] && !hk[k+1]) begin
            e   = sat32(ht[k] - hy[k]);
            omy = sat32((64'sd1 <<< FR) - hy[k]);
            p   = fmul(e, hy[k]);
            sq  = fmul(e, e);
            m_ov = 1'b1;
            m_delta = fmul(p, omy);
            for (int i = 0; i < 3; i++) begin
                mask = (64'sd1 <<< accw[i]) - 1;
                sum  = m_acc[i] + sq;
                if (SAT) sum = (sum > mask) ? mask : sum;
                else     sum = sum & mask;
                m_cnt[i]++;
                if (m_cnt[i] == ns[i]) begin
                    m_sse[i] = sum; m_acc[i] = 0; m_cnt[i] = 0; m_ed[i] = 1'b1;
                end else begin
                    m_acc[i] = sum; m_ed[i] = 1'b0;
                end
            end
        end else begin
            m_ov = 1'b0;
            for (int i = 0; i < 3; i++) m_ed[i] = 1'b0;
        end
    endtask

    task automatic compare_all();
        logic        ov_o[3];
        logic        ed_o[3];
        logic [63:0] d_o[3];
        logic [63:0] s_o[3];
        logic [63:0] c_o[3];
        ov_o = '{ov0, ov1, ov2};
        ed_o = '{ed0, ed1, ed2};
        d_o  = '{64'(d0), 64'(d1), 64'(d2)};
        s_o  = '{64'(s0), 64'(s1), 64'(s2)};
        c_o  = '{64'(c0), 64'(c1), 64'(c2)};
        for (int i = 0; i < 3; i++) begin
            check($sformatf("out_valid%0d@%0d", i, n), 64'(ov_o[i]), 64'(m_ov));
            check($sformatf("epoch_done%0d@%0d", i, n), 64'(ed_o[i]), 64'(m_ed[i]));
            check($sformatf("sample_cnt%0d@%0d", i, n), c_o[i], 64'(m_cnt[i]));
            check($sformatf("sse%0d@%0d", i, n), s_o[i], m_sse[i]);
            if (m_ov) check($sformatf("delta%0d@%0d", i, n), d_o[i], {32'h0, m_delta[31:0]});
        end
    endtask

    task automatic step(input bit v, input logic [31:0] yy, input logic [31:0] tt,
                        input bit c, input bit r);
        in_valid = v; y = yy; target = tt; clr = c; rst = r;
        @(posedge clk);
        n++;
        hv[n] = v; hk[n] = c | r;
        hy[n] = longint'($signed(yy));
        ht[n] = longint'($signed(tt));
        model_update(r, c);
        #1;
        compare_all();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [39:0] sse_hold;
        // reset
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        check("rst_delta", 64'(d0), 64'h0);
        idle(1);

        // T1: back-to-back y=0.5, t=1.0
        for (int i = 0; i < 4; i++) step(1'b1, 32'h00800000, 32'h01000000, 1'b0, 1'b0);
        idle(4);
        check("t1_delta", 64'(d0), 64'h00200000);
        check("t1_sse", 64'(s0), 64'h0001000000);

        // T2: y=1.0, t=0 with 2-cycle gaps
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h01000000, 32'h00000000, 1'b0, 1'b0);
            idle(2);
        end
        idle(2);
        check("t2_delta", 64'(d0), 64'h0);
        check("t2_sse", 64'(s0), 64'h0004000000);

        // T3: clean epoch on the narrow-accumulator instance
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h01000000, 32'h00000000, 1'b0, 1'b0);
        idle(4);
        check("t3_sse", 64'(s1), SAT ? 64'h1FFFFFF : 64'h1000000);

        // T4: clr together with the 3rd sample drops all three
        sse_hold = s0;
        step(1'b1, 32'h00800000, 32'h01000000, 1'b0, 1'b0);
        step(1'b1, 32'h00800000, 32'h01000000, 1'b0, 1'b0);
        step(1'b1, 32'h00800000, 32'h01000000, 1'b1, 1'b0);
        idle(4);
        check("t4_cnt", 64'(c0), 64'h0);
        check("t4_sse_held", 64'(s0), 64'(sse_hold));
        for (int i = 0; i < 4; i++) step(1'b1, 32'h00800000, 32'h01000000, 1'b0, 1'b0);
        idle(4);
        check("t4_sse", 64'(s0), 64'h0001000000);

        // T5: extreme inputs saturate rather than wrap
        step(1'b1, 32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b0);
        idle(2);
        check("t5_valid", 64'(ov0), 64'h1);
        check("t5_delta", 64'(d0), 64'h7FFFFFFF);
        idle(2);

        // randomized traffic with occasional clr
        for (int i = 0; i < 150; i++) begin
            logic [31:0] ry, rt;
            ry = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 32'h01FFFFFF);
            rt = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 32'h01FFFFFF);
            step($urandom_range(0, 9) < 7, ry, rt, $urandom_range(0, 19) == 0, 1'b0);
        end
        idle(4);

        // T6: rst one cycle after epoch_done
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 32'h00800000, 32'h01000000, 1'b0, 1'b0);
        for (int k = 0; k < 8 && !ed0; k++) idle(1);
        check("t6_done_seen", 64'(ed0), 64'h1);
        idle(1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        check("t6_sse", 64'(s0), 64'h0);
        check("t6_cnt", 64'(c0), 64'h0);
        check("t6_valid", 64'(ov0), 64'h0);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
